// File: rtl/ysyx_23060191_mem_arbiter.sv
// -----------------------------------------------------------------------------
// ysyx_23060191_mem_arbiter
//
// Shares one memory port between the IFU (read-only fetches) and the LSU
// (loads and stores). Only one transaction is in flight at a time. The
// request path is registered; the response path is a combinational
// passthrough that is steered to whichever master owns the transaction.
//
// Handshake rule used on every channel: a transfer happens on a rising clock
// edge where valid and ready are both 1. A source holds valid and its
// payload stable until that edge; ready may depend combinationally on valid.
//
// Configuration macro:
//   YSYX_23060191_ARB_RR_EN  defined   -> round-robin arbitration on contention
//                            undefined -> fixed priority, LSU over IFU
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   ifu_req_*                 IFU request  (valid/ready/addr)
//   ifu_resp_*                IFU response (valid/ready/data)
//   lsu_req_*                 LSU request  (valid/ready/addr/wen/wdata/wmask)
//   lsu_resp_*                LSU response (valid/ready/data; data 0 on store ack)
//   mem_req_*                 registered request towards memory
//   mem_resp_*                response from memory
//   dbg_state                 FSM state: 0=IDLE, 1=REQ, 2=RESP
// -----------------------------------------------------------------------------
module ysyx_23060191_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_resp_data,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_data,

    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    // Cleared by reset and set on the first clock edge afterwards, so no
    // request is offered a ready while reset is held.
    logic                r_live;

    logic                w_grant_ifu;
    logic                w_grant_lsu;
    logic                w_accept;

    // -------------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE; qualified by the FSM below)
    // -------------------------------------------------------------------------
`ifdef YSYX_23060191_ARB_RR_EN
    // Remembers which master won the most recent accept; on contention the
    // other master is preferred.
    logic r_last_grant;

    always_comb begin
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
            if (r_last_grant == OWNER_LSU) begin
                w_grant_ifu = 1'b1;
            end else begin
                w_grant_lsu = 1'b1;
            end
        end else begin
            w_grant_ifu = ifu_req_valid;
            w_grant_lsu = lsu_req_valid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= OWNER_IFU;
        end else if (w_accept) begin
            r_last_grant <= w_grant_lsu ? OWNER_LSU : OWNER_IFU;
        end
    end
`else
    // Fixed priority: the LSU always wins, the IFU only when the LSU is idle.
    assign w_grant_lsu = lsu_req_valid;
    assign w_grant_ifu = ifu_req_valid & ~lsu_req_valid;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_data  = '0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = '0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A grant implies the granted master's valid is high, so
                // ready here is also the handshake condition.
                ifu_req_ready = r_live & w_grant_ifu;
                lsu_req_ready = r_live & w_grant_lsu;
                w_accept      = r_live & (w_grant_ifu | w_grant_lsu);
                if (w_accept) begin
                    w_state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_nxt = ST_RESP;
                end
            end

            ST_RESP: begin
                if (r_owner == OWNER_LSU) begin
                    lsu_resp_valid = mem_resp_valid;
                    // A store ack carries no data.
                    lsu_resp_data  = r_wen ? '0 : mem_resp_data;
                    mem_resp_ready = lsu_resp_ready;
                end else begin
                    ifu_resp_valid = mem_resp_valid;
                    ifu_resp_data  = mem_resp_data;
                    mem_resp_ready = ifu_resp_ready;
                end
                if (mem_resp_valid && mem_resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request payload and owner registers, captured on the IDLE accept
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner <= OWNER_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            if (w_grant_lsu) begin
                r_owner <= OWNER_LSU;
                r_addr  <= lsu_req_addr;
                r_wen   <= lsu_req_wen;
                r_wdata <= lsu_req_wdata;
                r_wmask <= lsu_req_wmask;
            end else begin
                // Fetches are always plain reads.
                r_owner <= OWNER_IFU;
                r_addr  <= ifu_req_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
            end
        end
    end

    assign mem_req_addr  = r_addr;
    assign mem_req_wen   = r_wen;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wmask = r_wmask;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for ysyx_23060191_mem_arbiter. The bench plays both masters and the
// memory. Expected values come from a transaction-level model: which master
// wins, what the memory must see for that master's request, and what data
// the owner must get back.
// -----------------------------------------------------------------------------
module tb_ysyx_23060191_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              ifu_req_valid, ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid, ifu_resp_ready;
    logic [DATA_W-1:0] ifu_resp_data;
    logic              lsu_req_valid, lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid, lsu_resp_ready;
    logic [DATA_W-1:0] lsu_resp_data;
    logic              mem_req_valid, mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid, mem_resp_ready;
    logic [DATA_W-1:0] mem_resp_data;
    logic [1:0]        dbg_state;

    ysyx_23060191_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data),
        .dbg_state(dbg_state)
    );

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd2;

    // ------------------------------------------------------------ bookkeeping
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model state: which master was granted most recently.
    bit model_last_lsu = 1'b0;
    int exp_memreq     = 0;
    int seen_memreq    = 0;

    always @(posedge clk) begin
        if (rstn && mem_req_valid && mem_req_ready) seen_memreq++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Winner according to the arbitration rules.
    function automatic bit pick_lsu(input bit ifu_v, input bit lsu_v);
        if (ifu_v && lsu_v) begin
`ifdef YSYX_23060191_ARB_RR_EN
            return !model_last_lsu;
`else
            return 1'b1;
`endif
        end
        return lsu_v;
    endfunction

    // Called at a falling edge with request inputs already applied.
    task automatic accept(input bit exp_lsu);
        #1;
        chk("ifu_req_ready", ifu_req_ready, !exp_lsu);
        chk("lsu_req_ready", lsu_req_ready, exp_lsu);
        chk("mem_req_valid_idle", mem_req_valid, 0);
        @(posedge clk);
        @(negedge clk);
        if (exp_lsu) lsu_req_valid = 1'b0;
        else         ifu_req_valid = 1'b0;
        model_last_lsu = exp_lsu;
    endtask

    // Runs the memory side of one accepted transaction and checks both the
    // request presented to memory and the response returned to the owner.
    task automatic serve(input bit lsu, input logic [31:0] addr, input bit wen,
                         input logic [31:0] wdata, input logic [3:0] wmask,
                         input logic [31:0] rdata, input int req_wait,
                         input int resp_wait);
        bit          e_wen;
        logic [31:0] e_wdata;
        logic [3:0]  e_wmask;
        logic [31:0] e_rdata;
        bit          last;
        e_wen   = lsu && wen;
        e_wdata = lsu ? wdata : 32'h0;
        e_wmask = lsu ? wmask : 4'h0;
        e_rdata = e_wen ? 32'h0 : rdata;
        exp_memreq++;

        for (int k = 0; k <= req_wait; k++) begin
            mem_req_ready  = (k == req_wait);
            // Stray memory response while the request is pending.
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            ifu_resp_ready = 1'($urandom_range(0, 1));
            lsu_resp_ready = 1'($urandom_range(0, 1));
            #1;
            chk("mem_req_valid", mem_req_valid, 1);
            chk("mem_req_addr", mem_req_addr, addr);
            chk("mem_req_wen", mem_req_wen, e_wen);
            chk("mem_req_wdata", mem_req_wdata, e_wdata);
            chk("mem_req_wmask", mem_req_wmask, e_wmask);
            chk("ifu_req_ready_busy", ifu_req_ready, 0);
            chk("lsu_req_ready_busy", lsu_req_ready, 0);
            chk("mem_resp_ready_req", mem_resp_ready, 0);
            chk("ifu_resp_valid_req", ifu_resp_valid, 0);
            chk("lsu_resp_valid_req", lsu_resp_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end
        mem_req_ready = 1'b0;

        for (int k = 0; k <= resp_wait; k++) begin
            last           = (k == resp_wait);
            mem_resp_valid = 1'b1;
            mem_resp_data  = rdata;
            ifu_resp_ready = lsu ? !last : last;
            lsu_resp_ready = lsu ? last : !last;
            #1;
            if (lsu) begin
                chk("lsu_resp_valid", lsu_resp_valid, 1);
                chk("lsu_resp_data", lsu_resp_data, e_rdata);
                chk("ifu_resp_valid_other", ifu_resp_valid, 0);
            end else begin
                chk("ifu_resp_valid", ifu_resp_valid, 1);
                chk("ifu_resp_data", ifu_resp_data, e_rdata);
                chk("lsu_resp_valid_other", lsu_resp_valid, 0);
            end
            chk("mem_resp_ready", mem_resp_ready, last);
            chk("mem_req_valid_resp", mem_req_valid, 0);
            chk("state_resp", dbg_state, ST_RESP);
            @(posedge clk);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
        #1;
        chk("state_idle_after", dbg_state, ST_IDLE);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] ia, la, lwd, rd1, rd2;
        logic [3:0]  lm;
        bit          lw, iv, lv, win;
        int          sel;

        rstn           = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_req_addr   = 32'h8000_0000;
        ifu_resp_ready = 1'b1;
        lsu_req_valid  = 1'b1;
        lsu_req_addr   = 32'h0;
        lsu_req_wen    = 1'b0;
        lsu_req_wdata  = 32'h0;
        lsu_req_wmask  = 4'h0;
        lsu_resp_ready = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hFFFF_FFFF;

        // Reset state with every input pushing for activity.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ifu_req_ready", ifu_req_ready, 0);
        chk("rst_lsu_req_ready", lsu_req_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_resp_ready", mem_resp_ready, 0);
        chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
        chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
        chk("rst_payload", {mem_req_addr, mem_req_wen, mem_req_wmask}, 0);
        chk("rst_wdata", mem_req_wdata, 0);
        chk("rst_state", dbg_state, ST_IDLE);

        @(negedge clk);
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        rstn           = 1'b1;
        @(negedge clk);

        // Reset in the middle of an IFU transaction.
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0040;
        accept(1'b0);
        mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hA5A5_5A5A;
        ifu_resp_ready = 1'b1;
        #1;
        chk("mid_ifu_resp_valid", ifu_resp_valid, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ifu_resp_valid", ifu_resp_valid, 0);
        chk("mid_rst_mem_resp_ready", mem_resp_ready, 0);
        chk("mid_rst_state", dbg_state, ST_IDLE);
        chk("mid_rst_addr", mem_req_addr, 0);
        @(negedge clk);
        rstn           = 1'b1;
        model_last_lsu = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("post_rst_ifu_resp_valid", ifu_resp_valid, 0);
            chk("post_rst_mem_resp_ready", mem_resp_ready, 0);
            chk("post_rst_state", dbg_state, ST_IDLE);
        end
        mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        @(negedge clk);
        exp_memreq  = 0;
        seen_memreq = 0;

        // Single IFU fetch with zero-wait memory.
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        accept(1'b0);
        serve(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 0, 0);

        // LSU store with the memory stalling the request for 3 cycles.
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_wmask = 4'hF;
        accept(1'b1);
        serve(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'hCAFE_F00D, 3, 0);

        // Response backpressure for 4 cycles.
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0010;
        accept(1'b0);
        serve(1'b0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 0, 4);

        // Both masters request together; the loser keeps its valid up.
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0020;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_2000;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = 32'h1111_2222;
        lsu_req_wmask = 4'h3;
        win = pick_lsu(1'b1, 1'b1);
        accept(win);
        if (win) serve(1'b1, 32'h8000_2000, 1'b0, 32'h1111_2222, 4'h3, 32'h0BAD_F00D, 0, 1);
        else     serve(1'b0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 1);
        accept(!win);
        if (!win) serve(1'b1, 32'h8000_2000, 1'b0, 32'h1111_2222, 4'h3, 32'h7777_8888, 1, 0);
        else      serve(1'b0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h7777_8888, 1, 0);

        // Eight back-to-back fetches.
        for (int k = 0; k < 8; k++) begin
            ifu_req_valid = 1'b1;
            ifu_req_addr  = 32'h8000_0000 + 32'(4 * k);
            rd1           = $urandom;
            accept(1'b0);
            serve(1'b0, 32'h8000_0000 + 32'(4 * k), 1'b0, 32'h0, 4'h0, rd1, 0, 0);
        end
        chk("memreq_count_b2b", seen_memreq, exp_memreq);

        // Random mix of fetches, loads, stores and contention.
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 2);
            iv  = (sel != 1);
            lv  = (sel != 0);
            ia  = $urandom;
            la  = $urandom;
            lw  = 1'($urandom_range(0, 1));
            lwd = $urandom;
            lm  = 4'($urandom_range(0, 15));
            rd1 = $urandom;
            rd2 = $urandom;
            ifu_req_valid = iv;
            ifu_req_addr  = ia;
            lsu_req_valid = lv;
            lsu_req_addr  = la;
            lsu_req_wen   = lw;
            lsu_req_wdata = lwd;
            lsu_req_wmask = lm;
            win = pick_lsu(iv, lv);
            accept(win);
            serve(win, win ? la : ia, lw, lwd, lm, rd1,
                  $urandom_range(0, 3), $urandom_range(0, 3));
            if (iv && lv) begin
                accept(!win);
                serve(!win, !win ? la : ia, lw, lwd, lm, rd2,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
        chk("memreq_count_total", seen_memreq, exp_memreq);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_mem_arbiter.md
Name: ysyx_23060191_mem_arbiter

Overview:
Two-master, single-slave arbiter that shares one memory port between the IFU (instruction fetch, read-only) and the LSU (loads and stores).
- Registers the winning request and drives it to the memory side.
- Returns the response only to the master that owns the transaction.
- One transaction outstanding at a time; sits between IFU/LSU and the memory/DPI bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MASK_W, 4, byte write-mask width (DATA_W/8)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
ifu_req_valid  input  1  IFU read request
ifu_req_ready  output  1  IFU request accepted
ifu_req_addr  input  ADDR_W  fetch address
ifu_resp_valid  output  1  instruction data valid
ifu_resp_ready  input  1  IFU accepts response
ifu_resp_data  output  DATA_W  instruction word
lsu_req_valid  input  1  LSU request
lsu_req_ready  output  1  LSU request accepted
lsu_req_addr  input  ADDR_W  load/store address
lsu_req_wen  input  1  1=store, 0=load
lsu_req_wdata  input  DATA_W  store data
lsu_req_wmask  input  MASK_W  store byte mask
lsu_resp_valid  output  1  load data / store ack valid
lsu_resp_ready  input  1  LSU accepts response
lsu_resp_data  output  DATA_W  load data (0 for store ack)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  registered address
mem_req_wen  output  1  registered write enable
mem_req_wdata  output  DATA_W  registered write data
mem_req_wmask  output  MASK_W  registered mask (0 for IFU)
mem_resp_valid  input  1  memory response
mem_resp_ready  output  1  arbiter accepts response
mem_resp_data  input  DATA_W  read data

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, owner=IFU.
  - All *_valid and *_ready outputs 0.
  - mem_req_* payload registers 0.
  - Any in-flight transaction is abandoned; no response is delivered after reset release.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Winner selected combinationally; default policy is fixed priority, LSU over IFU.
  - Winner's *_req_ready=1 (only when its valid=1); loser's ready=0.
  - On handshake: latch addr/wen/wdata/wmask and owner, go to REQ.
  - IFU payload latched as wen=0, wmask=0, wdata=0.
- REQ:
  - mem_req_valid=1 with registered payload, stable until mem_req_ready.
  - On mem_req_ready, go to RESP.
  - Both master req_ready=0.
- RESP:
  - owner_resp_valid=mem_resp_valid; owner_resp_data=mem_resp_data, forced to 0 when owner=LSU and wen=1.
  - mem_resp_ready=owner_resp_ready; non-owner resp_valid=0.
  - On mem handshake, go to IDLE.
- Latency: request accepted cycle N → mem_req_valid at N+1. With zero-wait memory (ready and resp in the cycle after), the master sees the response at N+2. Next accept no earlier than the cycle after the response handshake.
- Simultaneous IFU+LSU valid in IDLE: LSU wins. IFU keeps its valid asserted and is served in the next IDLE.
- mem_resp_valid outside RESP is ignored (mem_resp_ready=0).
- Response passthrough is combinational; only the request path is registered.
- Masters must hold valid/payload until ready; deasserting valid before ready is a protocol violation.

Optional Feature:
- Macro YSYX_23060191_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register (reset=IFU) is updated at each IDLE accept. On contention the master not granted last wins; without contention the sole requester wins.
- Undefined: fixed LSU priority; no last_grant register.

Test Plan:
- Reset mid-transaction: IFU accepted, assert rstn=0 during RESP with mem_resp_valid=1 → ifu_resp_valid=0 immediately; state IDLE after release; all outputs 0.
- Single IFU fetch, addr=0x80000000, memory ready next cycle, returns 0x00000413 → mem_req_valid at N+1 with addr 0x80000000, wen=0, wmask=0; ifu_resp_data=0x00000413 at N+2; lsu_resp_valid stays 0.
- LSU store, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF → mem_req_wen=1 with payload held until mem_req_ready (delayed 3 cycles); lsu_resp_valid=1 with lsu_resp_data=0.
- IFU and LSU valid same cycle (default build) → LSU granted first, IFU granted in the IDLE after the LSU response. With YSYX_23060191_ARB_RR_EN and last_grant=LSU → IFU granted first.
- Backpressure: ifu_resp_ready=0 for 4 cycles while mem_resp_valid=1 → mem_resp_ready=0, data held at 0x12345678, state stays RESP; handshake on the 5th cycle → IDLE.
- Back-to-back: 8 IFU fetches, addr 0x80000000+4k → exactly 8 mem requests in order, 8 responses to IFU, no spurious LSU traffic.
